gate_vector_checker: RTL and testbench
======================================

GATE_VECTOR_CHECKER -- requirements
Module: gate_vector_checker

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: idle cycles between driving a vector and sampling the gate outputs; legal range 1..15.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  request one full 4-vector check run; sampled on clk.
REQ-005 a_out  output  1  A operand driven to the gate block under test.
REQ-006 b_out  output  1  B operand driven to the gate block under test.
REQ-007 c_in, d_in, e_in, f_in, g_in, h_in  input  1 each  AND, NAND, NOR, XOR, XNOR and NOT-A results returned from the gate block.
REQ-008 busy  output  1  high while a run is in progress.
REQ-009 done  output  1  one-cycle pulse marking the end of a run.
REQ-010 pass  output  1  run verdict, valid from done until the next accepted start.
REQ-011 err_count  output  3  number of vectors with at least one mismatch (0..4).
REQ-012 err_mask  output  6  sticky per-output mismatch flags for the run; bit5..bit0 = c,d,e,f,g,h.

Function
REQ-013 The FSM SHALL have states IDLE, DRIVE, SETTLE, CHECK and DONE.
REQ-014 IDLE: start=1 SHALL move to DRIVE, clear vec_idx, err_count and err_mask, and clear pass.
REQ-015 DRIVE: a_out SHALL be vec_idx[1] and b_out SHALL be vec_idx[0]; the state SHALL advance to SETTLE after exactly one cycle.
REQ-016 Vector order SHALL be (a,b) = 00, 01, 10, 11.
REQ-017 SETTLE SHALL last exactly SETTLE_CYCLES cycles, counted by an internal 4-bit counter, and then advance to CHECK.
REQ-018 a_out and b_out SHALL be held stable from DRIVE through CHECK and SHALL change only on entry to the next DRIVE.
REQ-019 CHECK (one cycle) SHALL compare the inputs against the expected values:
  - c = a&b, d = ~(a&b), e = ~(a|b)
  - f = a^b, g = ~(a^b), h = ~a
REQ-020 In CHECK, each mismatching output SHALL OR-set its err_mask bit, and err_count SHALL increment by 1 if any bit mismatches; err_count cannot exceed 4, so no saturation logic is required.
REQ-021 CHECK with vec_idx < 3 SHALL increment vec_idx and go to DRIVE; with vec_idx = 3 it SHALL go to DONE without wrapping vec_idx.
REQ-022 DONE SHALL last one cycle with done=1, SHALL set pass=1 if and only if err_count=0, and SHALL return to IDLE.
REQ-023 busy SHALL be 1 in DRIVE, SETTLE and CHECK, and 0 in IDLE and DONE.
REQ-024 start SHALL be ignored in every state except IDLE; start held high continuously SHALL launch back-to-back runs, separated by the DONE and IDLE cycles.
REQ-025 Latency: with start sampled at edge 0, DONE SHALL be entered at edge 4*(SETTLE_CYCLES+2), i.e. edge 16 for the default.
REQ-026 In IDLE, a_out/b_out SHALL hold their last values, and err_count, err_mask and pass SHALL hold their last run results.

Reset
REQ-027 With rst_n=0 at a clk edge, the FSM SHALL go to IDLE and set all outputs to 0: a_out, b_out, busy, done, pass, err_count, err_mask.
REQ-028 vec_idx and the settle counter SHALL also reset to 0.
REQ-029 Reset asserted mid-run SHALL abort the run at that edge with no done pulse; a new start is required after rst_n returns high.

Verification
REQ-030 Correct gate model, SETTLE_CYCLES=2, one-cycle start pulse -> a_out/b_out sequence 00,01,10,11; done at edge 16; pass=1, err_count=0, err_mask=000000.
REQ-031 h_in stuck at 0 -> mismatch on vectors 00 and 01; err_count=2, err_mask=000001, pass=0.
REQ-032 c_in driven as a|b -> mismatch on vectors 01 and 10; err_count=2, err_mask=100000.
REQ-033 All six inputs inverted -> err_count=4, err_mask=111111, pass=0.
REQ-034 start pulsed during SETTLE of vector 01 -> no restart; exactly one done pulse at edge 16.
REQ-035 rst_n=0 for one cycle during CHECK of vector 10 -> next cycle IDLE with all outputs 0; no done pulse; a following start completes a normal run.

Source files
------------

// File: rtl/gate_vector_checker.sv
// Drives the four (a,b) operand vectors into an external two-input gate block
// and scores its six results. A full run takes 4*(SETTLE_CYCLES+2) cycles from start to done.
module gate_vector_checker #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  input  logic       c_in,
  input  logic       d_in,
  input  logic       e_in,
  input  logic       f_in,
  input  logic       g_in,
  input  logic       h_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [5:0] err_mask
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  vec_idx_q, vec_idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        a_q, a_d;
  logic        b_q, b_d;
  logic        pass_q, pass_d;
  logic [2:0]  err_count_q, err_count_d;
  logic [5:0]  err_mask_q, err_mask_d;

  logic [5:0]  exp_vec;
  logic [5:0]  got_vec;
  logic [5:0]  mismatch;
  logic [1:0]  nxt_idx;

  // Expected gate results for the operands currently on a_out/b_out.
  assign exp_vec  = {a_q & b_q, ~(a_q & b_q), ~(a_q | b_q),
                     a_q ^ b_q, ~(a_q ^ b_q), ~a_q};
  assign got_vec  = {c_in, d_in, e_in, f_in, g_in, h_in};
  assign mismatch = got_vec ^ exp_vec;
  assign nxt_idx  = vec_idx_q + 2'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_DRIVE;
      S_DRIVE:  state_d = S_SETTLE;
      S_SETTLE: if (cnt_q == SETTLE_LAST) state_d = S_CHECK;
      S_CHECK:  state_d = (vec_idx_q == 2'd3) ? S_DONE : S_DRIVE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_DRIVE, S_SETTLE, S_CHECK: busy = 1'b1;
      S_DONE:                     done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    vec_idx_d   = vec_idx_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    pass_d      = pass_q;
    err_count_d = err_count_q;
    err_mask_d  = err_mask_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          vec_idx_d   = 2'd0;
          a_d         = 1'b0;
          b_d         = 1'b0;
          pass_d      = 1'b0;
          err_count_d = 3'd0;
          err_mask_d  = 6'd0;
        end
      end
      S_DRIVE:  cnt_d = 4'd0;
      S_SETTLE: cnt_d = cnt_q + 4'd1;
      S_CHECK: begin
        err_mask_d  = err_mask_q | mismatch;
        err_count_d = err_count_q + {2'b00, |mismatch};
        if (vec_idx_q != 2'd3) begin
          // Operands change only here, on entry to the next DRIVE.
          vec_idx_d = nxt_idx;
          a_d       = nxt_idx[1];
          b_d       = nxt_idx[0];
        end else begin
          pass_d = (err_count_q == 3'd0) && !(|mismatch);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec_idx_q   <= 2'd0;
      cnt_q       <= 4'd0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= 3'd0;
      err_mask_q  <= 6'd0;
    end else begin
      vec_idx_q   <= vec_idx_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      pass_q      <= pass_d;
      err_count_q <= err_count_d;
      err_mask_q  <= err_mask_d;
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign err_mask  = err_mask_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Bench for gate_vector_checker: a configurable, possibly faulty gate block
// and a per-vector reference model of the expected verdict.
module tb_gate_vector_checker;

  localparam int S   = 2;
  localparam int LAT = 4 * (S + 2);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       a_out, b_out;
  logic       c_in, d_in, e_in, f_in, g_in, h_in;
  logic       busy, done, pass;
  logic [2:0] err_count;
  logic [5:0] err_mask;

  int checks = 0;
  int errors = 0;

  int         mode = 0;
  logic [5:0] rnd_tbl [4];

  int         done_edges[$];
  logic [1:0] ab_seq[$];
  logic [1:0] busy_at_last;

  gate_vector_checker #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_out(a_out), .b_out(b_out),
    .c_in(c_in), .d_in(d_in), .e_in(e_in), .f_in(f_in), .g_in(g_in), .h_in(h_in),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .err_mask(err_mask)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] ideal(input logic a, input logic b);
    return {a & b, ~(a & b), ~(a | b), a ^ b, ~(a ^ b), ~a};
  endfunction

  // Gate block under test, with selectable faults.
  always_comb begin
    logic [5:0] r;
    r = ideal(a_out, b_out);
    case (mode)
      1: r[0] = 1'b0;
      2: r[5] = a_out | b_out;
      3: r = ~r;
      4: r = r ^ rnd_tbl[{a_out, b_out}];
      default: ;
    endcase
    {c_in, d_in, e_in, f_in, g_in, h_in} = r;
  end

  // Pulse (or hold) start so it is sampled at edge 0, then watch n edges.
  task automatic run_observe(input int n, input int extra_edge, input bit hold);
    logic [1:0] last;
    bit first;
    done_edges.delete();
    ab_seq.delete();
    first = 1'b1;
    last = 2'b00;
    busy_at_last = 2'b00;
    @(negedge clk) start = 1'b1;
    for (int k = 0; k <= n; k++) begin
      @(posedge clk);
      #1;
      if (done) done_edges.push_back(k);
      if (busy && (first || {a_out, b_out} != last)) begin
        ab_seq.push_back({a_out, b_out});
        last = {a_out, b_out};
        first = 1'b0;
      end
      if (k == LAT - 1) busy_at_last[1] = busy;
      if (k == LAT)     busy_at_last[0] = busy;
      start = hold || (k + 1 == extra_edge);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({a_out, b_out, busy, done, pass, err_count, err_mask} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=0",
               {a_out, b_out, busy, done, pass, err_count, err_mask});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_correct;
    mode = 0;
    run_observe(LAT + 4, -1, 1'b0);
    checks++;
    if (done_edges.size() != 1 || done_edges[0] != LAT) begin
      errors++;
      $display("FAIL correct_done_edge got_n=%0d first=%0d want one at %0d",
               done_edges.size(), (done_edges.size() > 0) ? done_edges[0] : -1, LAT);
    end
    checks++;
    if (ab_seq.size() != 4 || ab_seq[0] != 2'b00 || ab_seq[1] != 2'b01 ||
        ab_seq[2] != 2'b10 || ab_seq[3] != 2'b11) begin
      errors++;
      $display("FAIL correct_ab_seq got_n=%0d want 00,01,10,11", ab_seq.size());
    end
    checks++;
    if (busy_at_last !== 2'b10) begin
      errors++;
      $display("FAIL correct_busy_window got=%b want=10", busy_at_last);
    end
    checks++;
    if ({pass, err_count, err_mask} !== {1'b1, 3'd0, 6'd0}) begin
      errors++;
      $display("FAIL correct_verdict got pass=%b cnt=%0d mask=%b want 1/0/000000",
               pass, err_count, err_mask);
    end
  endtask

  task automatic test_faults;
    logic [2:0] want_cnt[4] = '{3'd0, 3'd2, 3'd2, 3'd4};
    logic [5:0] want_msk[4] = '{6'b000000, 6'b000001, 6'b100000, 6'b111111};
    for (int m = 1; m <= 3; m++) begin
      mode = m;
      run_observe(LAT + 2, -1, 1'b0);
      checks++;
      if ({pass, err_count, err_mask} !== {1'b0, want_cnt[m], want_msk[m]}) begin
        errors++;
        $display("FAIL fault_mode%0d got pass=%b cnt=%0d mask=%b want 0/%0d/%b",
                 m, pass, err_count, err_mask, want_cnt[m], want_msk[m]);
      end
    end
  endtask

  task automatic test_random;
    int exp_cnt;
    logic [5:0] exp_msk;
    mode = 4;
    for (int it = 0; it < 8; it++) begin
      exp_cnt = 0;
      exp_msk = 6'd0;
      for (int v = 0; v < 4; v++) begin
        rnd_tbl[v] = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom);
        if (rnd_tbl[v] != 6'd0) exp_cnt++;
        exp_msk |= rnd_tbl[v];
      end
      run_observe(LAT + 1, -1, 1'b0);
      checks++;
      if (err_count !== 3'(exp_cnt) || err_mask !== exp_msk || pass !== (exp_cnt == 0)) begin
        errors++;
        $display("FAIL random_%0d got pass=%b cnt=%0d mask=%b want %0d/%0d/%b",
                 it, pass, err_count, err_mask, exp_cnt == 0, exp_cnt, exp_msk);
      end
      // Results must persist while idle.
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (err_count !== 3'(exp_cnt) || err_mask !== exp_msk || busy !== 1'b0) begin
        errors++;
        $display("FAIL random_hold_%0d got cnt=%0d mask=%b busy=%b want %0d/%b/0",
                 it, err_count, err_mask, busy, exp_cnt, exp_msk);
      end
    end
  endtask

  task automatic test_start_ignored;
    mode = 0;
    // Vector 01 is in SETTLE during the cycles before edges 6 and 7.
    run_observe(LAT + 12, S + 4, 1'b0);
    checks++;
    if (done_edges.size() != 1 || done_edges[0] != LAT) begin
      errors++;
      $display("FAIL start_ignored got_n=%0d first=%0d want one at %0d",
               done_edges.size(), (done_edges.size() > 0) ? done_edges[0] : -1, LAT);
    end
  endtask

  task automatic test_back_to_back;
    mode = 0;
    run_observe(2 * LAT + 3, -1, 1'b1);
    checks++;
    if (done_edges.size() != 2 || done_edges[0] != LAT || done_edges[1] != 2 * LAT + 2) begin
      errors++;
      $display("FAIL back_to_back got_n=%0d want done at %0d and %0d",
               done_edges.size(), LAT, 2 * LAT + 2);
    end
    repeat (LAT + 4) @(posedge clk);
  endtask

  task automatic test_mid_reset;
    int n_done;
    mode = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    // CHECK of vector 10 occupies the cycle before edge 3*(S+2).
    for (int k = 1; k < 3 * (S + 2); k++) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({a_out, b_out, busy, done, pass, err_count, err_mask} !== 14'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs got=%b want=0",
               {a_out, b_out, busy, done, pass, err_count, err_mask});
    end
    rst_n = 1'b1;
    n_done = 0;
    for (int k = 0; k < LAT + 4; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) n_done++;
    end
    checks++;
    if (n_done != 0) begin
      errors++;
      $display("FAIL mid_reset_no_restart got=%0d active cycles want=0", n_done);
    end
    run_observe(LAT + 2, -1, 1'b0);
    checks++;
    if (done_edges.size() != 1 || done_edges[0] != LAT || pass !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_rerun got_n=%0d pass=%b want one done at %0d pass=1",
               done_edges.size(), pass, LAT);
    end
  endtask

  task automatic test_pass_clear;
    mode = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    checks++;
    if (pass !== 1'b0 || busy !== 1'b1 || err_count !== 3'd0) begin
      errors++;
      $display("FAIL pass_clear got pass=%b busy=%b cnt=%0d want 0/1/0", pass, busy, err_count);
    end
    repeat (LAT + 2) @(posedge clk);
  endtask

  initial begin
    for (int v = 0; v < 4; v++) rnd_tbl[v] = 6'd0;
    test_reset();
    test_correct();
    test_faults();
    test_random();
    test_correct();
    test_pass_clear();
    test_start_ignored();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
